// File: rtl/three_x_eight_strobe_decoder_pkg.sv
// Shared types and constants for the 3-to-8 strobe decoder.
package three_x_eight_strobe_decoder_pkg;

  localparam int CODE_W              = 3;
  localparam int ONEHOT_W            = 8;
  localparam int CNT_W               = 8;
  localparam int HOLD_CYCLES_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/three_x_eight_strobe_decoder_if.sv
// Handshake and strobe bus between a code producer and the decoder.
interface three_x_eight_strobe_decoder_if;
  import three_x_eight_strobe_decoder_pkg::*;

  logic                abort;
  logic                in_valid;
  logic [CODE_W-1:0]   in_code;
  logic                in_ready;
  logic [ONEHOT_W-1:0] OUT;
  logic                out_valid;
  logic                busy;
  logic [CNT_W-1:0]    decode_count;

  modport master (
    output abort, in_valid, in_code,
    input  in_ready, OUT, out_valid, busy, decode_count
  );

  modport slave (
    input  abort, in_valid, in_code,
    output in_ready, OUT, out_valid, busy, decode_count
  );

endinterface

// File: rtl/three_x_eight_strobe_decoder_onehot_3x8.sv
// Combinational binary-to-one-hot converter for a 3-bit code.
module onehot_3x8
  import three_x_eight_strobe_decoder_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] onehot
);

  // Table decode keeps the output free of X for every code value.
  always_comb begin
    case (code)
      3'd0:    onehot = 8'b0000_0001;
      3'd1:    onehot = 8'b0000_0010;
      3'd2:    onehot = 8'b0000_0100;
      3'd3:    onehot = 8'b0000_1000;
      3'd4:    onehot = 8'b0001_0000;
      3'd5:    onehot = 8'b0010_0000;
      3'd6:    onehot = 8'b0100_0000;
      3'd7:    onehot = 8'b1000_0000;
      default: onehot = 8'b0000_0000;
    endcase
  end

endmodule

// File: rtl/three_x_eight_strobe_decoder.sv
// Decodes accepted 3-bit codes into one-hot strobes held for HOLD_CYCLES cycles,
// with a single pending slot so consecutive strobes run back to back.
module three_x_eight_strobe_decoder
  import three_x_eight_strobe_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
)
(
  input  logic                           clk,
  input  logic                           rst,
  three_x_eight_strobe_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] RELOAD = 8'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   pend_code_q, pend_code_d;
  logic                pend_full_q, pend_full_d;
  logic [ONEHOT_W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    decode_count_q, decode_count_d;

  logic                in_ready_s;
  logic                accept_s;
  logic                load_s;
  logic                load_pend_s;
  logic [ONEHOT_W-1:0] in_onehot_s;
  logic [ONEHOT_W-1:0] pend_onehot_s;

  onehot_3x8 u_in_onehot (
    .code   (bus.in_code),
    .onehot (in_onehot_s)
  );

  onehot_3x8 u_pend_onehot (
    .code   (pend_code_q),
    .onehot (pend_onehot_s)
  );

  // Ready is withheld during reset and abort so neither can swallow a code.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst || bus.abort) begin
      in_ready_s = 1'b0;
    end else if (state_q == IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = !pend_full_q;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  // Next-state and output computation for the IDLE/HOLD machine.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_code_d    = pend_code_q;
    pend_full_d    = pend_full_q;
    out_d          = out_q;
    out_valid_d    = out_valid_q;
    decode_count_d = decode_count_q;
    load_s         = 1'b0;
    load_pend_s    = 1'b0;

    if (bus.abort) begin
      state_d     = IDLE;
      cnt_d       = 8'd0;
      pend_code_d = 3'd0;
      pend_full_d = 1'b0;
      out_d       = 8'd0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            load_s = 1'b1;
          end else begin
            out_d       = 8'd0;
            out_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (accept_s) begin
              pend_code_d = bus.in_code;
              pend_full_d = 1'b1;
            end else begin
              pend_full_d = pend_full_q;
            end
          end else if (pend_full_q) begin
            // Last hold cycle: chain straight into the buffered code.
            load_s      = 1'b1;
            load_pend_s = 1'b1;
            pend_full_d = 1'b0;
          end else if (accept_s) begin
            load_s = 1'b1;
          end else begin
            state_d     = IDLE;
            out_d       = 8'd0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = 8'd0;
          pend_full_d = 1'b0;
          out_d       = 8'd0;
          out_valid_d = 1'b0;
        end
      endcase

      if (load_s) begin
        state_d        = HOLD;
        out_d          = load_pend_s ? pend_onehot_s : in_onehot_s;
        out_valid_d    = 1'b1;
        cnt_d          = RELOAD;
        decode_count_d = decode_count_q + 8'd1;
      end else begin
        decode_count_d = decode_count_q;
      end
    end

    busy_d = (state_d == HOLD) || pend_full_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      pend_code_q    <= 3'd0;
      pend_full_q    <= 1'b0;
      out_q          <= 8'd0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      decode_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_code_q    <= pend_code_d;
      pend_full_q    <= pend_full_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      decode_count_q <= decode_count_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.OUT          = out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.decode_count = decode_count_q;

endmodule

// File: tb/tb_three_x_eight_strobe_decoder.sv
// Directed bench: one decoder with 4-cycle strobes, one with 1-cycle strobes,
// accepted codes queued and matched against each new strobe on OUT.
module tb_three_x_eight_strobe_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  three_x_eight_strobe_decoder_if a_if ();
  three_x_eight_strobe_decoder_if b_if ();

  three_x_eight_strobe_decoder #(.HOLD_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  three_x_eight_strobe_decoder #(.HOLD_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [2:0] qa[$];
  logic [2:0] qb[$];
  bit         a_acc, b_acc;
  bit         a_prev, a_flush;
  int         a_run, a_vrun, a_last_vrun;
  logic [7:0] a_cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_a();
    logic [2:0] e;
    logic [7:0] exp_oh;
    chk("a_onehot", 32'(!$isunknown(a_if.OUT) && ($countones(a_if.OUT) <= 1)), 32'd1);
    chk("a_valid_vs_out", 32'(a_if.out_valid), 32'(a_if.OUT != 8'd0));
    if (a_if.out_valid) begin
      if (!a_prev || a_run == 4) begin
        if (qa.size() == 0) begin
          chk("a_spurious", 32'(a_if.OUT), 32'd0);
        end else begin
          e      = qa.pop_front();
          exp_oh = 8'h01 << e;
          chk("a_strobe", 32'(a_if.OUT), 32'(exp_oh));
        end
        a_cur = a_if.OUT;
        a_run = 1;
      end else begin
        chk("a_hold", 32'(a_if.OUT), 32'(a_cur));
        a_run++;
      end
      a_vrun++;
    end else begin
      if (a_prev) begin
        if (!a_flush) chk("a_len", 32'(a_run), 32'd4);
        a_last_vrun = a_vrun;
      end
      a_vrun  = 0;
      a_run   = 0;
      a_flush = 1'b0;
    end
    a_prev = a_if.out_valid;
  endtask

  task automatic mon_b();
    logic [2:0] e;
    logic [7:0] exp_oh;
    chk("b_onehot", 32'(!$isunknown(b_if.OUT) && ($countones(b_if.OUT) <= 1)), 32'd1);
    if (b_if.out_valid) begin
      if (qb.size() == 0) begin
        chk("b_spurious", 32'(b_if.OUT), 32'd0);
      end else begin
        e      = qb.pop_front();
        exp_oh = 8'h01 << e;
        chk("b_strobe", 32'(b_if.OUT), 32'(exp_oh));
      end
    end
  endtask

  // One clock: record handshakes just before the edge, check just after it.
  task automatic cyc();
    @(negedge clk);
    a_acc = a_if.in_valid && a_if.in_ready;
    b_acc = b_if.in_valid && b_if.in_ready;
    if (a_acc) qa.push_back(a_if.in_code);
    if (b_acc) qb.push_back(b_if.in_code);
    @(posedge clk);
    #1;
    mon_a();
    mon_b();
  endtask

  task automatic send_a(input logic [2:0] code, output int waited);
    a_if.in_valid = 1'b1;
    a_if.in_code  = code;
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (!a_acc && waited < 20);
    if (!a_acc) chk("a_send_timeout", 32'd0, 32'd1);
  endtask

  int w;

  initial begin
    checks = 0; errors = 0;
    a_prev = 1'b0; a_flush = 1'b0; a_run = 0; a_vrun = 0; a_last_vrun = 0; a_cur = 8'd0;
    rst = 1'b1;
    a_if.abort = 1'b0; a_if.in_valid = 1'b1; a_if.in_code = 3'd3;
    b_if.abort = 1'b0; b_if.in_valid = 1'b0; b_if.in_code = 3'd0;

    // Reset: nothing accepted, outputs cleared
    cyc(); cyc(); cyc();
    chk("rst_ready", 32'(a_if.in_ready), 32'd0);
    chk("rst_out", 32'(a_if.OUT), 32'd0);
    chk("rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    chk("rst_count", 32'(a_if.decode_count), 32'd0);

    // Single code 5, first cycle after reset release
    rst = 1'b0;
    a_if.in_code = 3'd5;
    #1 chk("idle_ready", 32'(a_if.in_ready), 32'd1);
    send_a(3'd5, w);
    a_if.in_valid = 1'b0;
    chk("single_latency", 32'(a_if.OUT), 32'h20);
    chk("single_busy", 32'(a_if.busy), 32'd1);
    cyc(); cyc(); cyc();
    chk("single_last", 32'(a_if.out_valid), 32'd1);
    cyc();
    chk("single_end_out", 32'(a_if.OUT), 32'd0);
    chk("single_end_busy", 32'(a_if.busy), 32'd0);
    chk("single_count", 32'(a_if.decode_count), 32'd1);

    // Back-to-back 0,7,3
    send_a(3'd0, w);
    send_a(3'd7, w);
    a_if.in_code = 3'd3;
    #1 chk("b2b_ready_full", 32'(a_if.in_ready), 32'd0);
    send_a(3'd3, w);
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) cyc();
    chk("b2b_contiguous", 32'(a_last_vrun), 32'd12);
    chk("b2b_count", 32'(a_if.decode_count), 32'd4);

    // Bypass exactly on the counter=0 cycle
    send_a(3'd6, w);
    a_if.in_valid = 1'b0;
    cyc(); cyc(); cyc();
    a_if.in_valid = 1'b1; a_if.in_code = 3'd2;
    cyc();
    chk("bypass_acc", 32'(a_acc), 32'd1);
    chk("bypass_out", 32'(a_if.OUT), 32'h04);
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("bypass_contiguous", 32'(a_last_vrun), 32'd8);
    chk("bypass_count", 32'(a_if.decode_count), 32'd6);

    // Abort while 6 holds and 1 is pending
    send_a(3'd6, w);
    send_a(3'd1, w);
    a_if.in_valid = 1'b0;
    qa.delete();
    a_flush = 1'b1;
    a_if.abort = 1'b1;
    cyc();
    a_if.abort = 1'b0;
    chk("abort_out", 32'(a_if.OUT), 32'd0);
    for (int i = 0; i < 8; i++) cyc();
    chk("abort_idle", 32'(a_if.out_valid), 32'd0);
    chk("abort_busy", 32'(a_if.busy), 32'd0);
    chk("abort_count", 32'(a_if.decode_count), 32'd7);

    // Abort while idle blocks acceptance
    a_if.abort = 1'b1; a_if.in_valid = 1'b1; a_if.in_code = 3'd5;
    #1 chk("abort_ready", 32'(a_if.in_ready), 32'd0);
    cyc();
    a_if.abort = 1'b0; a_if.in_valid = 1'b0;
    cyc(); cyc();
    chk("abort_noaccept", 32'(a_if.out_valid), 32'd0);

    // Reset (with abort) mid-HOLD, then a normal decode
    send_a(3'd4, w);
    send_a(3'd5, w);
    a_if.in_code = 3'd7;
    qa.delete();
    a_flush = 1'b1;
    rst = 1'b1; a_if.abort = 1'b1;
    #1 chk("midrst_ready", 32'(a_if.in_ready), 32'd0);
    cyc(); cyc();
    chk("midrst_out", 32'(a_if.OUT), 32'd0);
    chk("midrst_busy", 32'(a_if.busy), 32'd0);
    chk("midrst_count", 32'(a_if.decode_count), 32'd0);
    rst = 1'b0; a_if.abort = 1'b0;
    send_a(3'd3, w);
    a_if.in_valid = 1'b0;
    chk("postrst_wait", 32'(w), 32'd1);
    chk("postrst_out", 32'(a_if.OUT), 32'h08);
    for (int i = 0; i < 6; i++) cyc();
    chk("postrst_count", 32'(a_if.decode_count), 32'd1);

    // HOLD_CYCLES=1: 257 streamed codes, wrap of decode_count
    for (int i = 0; i < 257; i++) begin
      b_if.in_valid = 1'b1;
      b_if.in_code  = 3'($urandom_range(0, 7));
      #1 chk("b_ready", 32'(b_if.in_ready), 32'd1);
      cyc();
    end
    b_if.in_valid = 1'b0;
    cyc(); cyc();
    chk("b_wrap_count", 32'(b_if.decode_count), 32'd1);
    chk("b_drained", 32'(qb.size()), 32'd0);
    chk("b_idle", 32'(b_if.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/three_x_eight_strobe_decoder.md
THREE_X_EIGHT_STROBE_DECODER -- requirements
Module: three_x_eight_strobe_decoder

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of clock cycles each decoded one-hot strobe is held; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 abort  input  1  synchronous flush of active strobe and pending code.
REQ-005 in_valid  input  1  in_code is valid this cycle.
REQ-006 in_code  input  3  binary code 0..7 to decode.
REQ-007 in_ready  output  1  block accepts in_code this cycle.
REQ-008 OUT  output  8  registered one-hot strobe; bit in_code set; all-zero when idle.
REQ-009 out_valid  output  1  high while OUT carries a strobe.
REQ-010 busy  output  1  high when state is HOLD or the pending slot is full.
REQ-011 decode_count  output  8  number of codes driven onto OUT, modulo 256.

Function
REQ-012 Handshake: a code is accepted on a cycle with in_valid=1 and in_ready=1; no other cycle consumes in_code.
REQ-013 FSM states: IDLE and HOLD; one pending slot (1 code + full flag) buffers one code during HOLD.
REQ-014 IDLE: in_ready=1, OUT=0, out_valid=0; on accept, next cycle OUT=1<<in_code, out_valid=1, hold counter=HOLD_CYCLES-1, state HOLD.
REQ-015 Latency: accept to OUT valid is exactly 1 cycle.
REQ-016 HOLD: OUT constant; the counter decrements once per cycle; in_ready = NOT pending_full.
REQ-017 Accept in HOLD with counter>0 stores the code in the pending slot.
REQ-018 HOLD with counter=0 and pending full: next cycle OUT=1<<pending code, counter reloaded, pending cleared, stays in HOLD; no idle gap.
REQ-019 HOLD with counter=0, pending empty and accept this cycle: bypass; next cycle OUT=1<<in_code, counter reloaded, stays in HOLD.
REQ-020 HOLD with counter=0, pending empty and no accept: next cycle OUT=0, out_valid=0, state IDLE.
REQ-021 Each strobe is high for exactly HOLD_CYCLES cycles; back-to-back strobes are contiguous.
REQ-022 HOLD_CYCLES=1: each strobe lasts one cycle; a continuous in_valid stream gives one strobe per cycle, with in_ready held at 1.
REQ-023 decode_count increments by 1 on each cycle that a new strobe is loaded into OUT, and wraps from 255 to 0.
REQ-024 abort=1: next cycle OUT=0, out_valid=0, pending cleared, counter=0, state IDLE; in_ready=0 during the abort cycle; decode_count unchanged.
REQ-025 abort and rst both high: rst takes priority.
REQ-026 OUT is always either all-zero or exactly one bit set; no X is ever driven.

Reset
REQ-027 While rst=1, at each clock edge: state=IDLE, OUT=0, out_valid=0, busy=0, pending cleared, counter=0, decode_count=0.
REQ-028 While rst=1, in_ready=0; no code is accepted during reset.
REQ-029 Reset asserted mid-HOLD discards the active strobe and the pending code with no further strobe cycles.
REQ-030 First accept possible on the first cycle after rst deasserts.

Structure
REQ-031 A shared package holds the state enum (IDLE, HOLD), CODE_W=3, ONEHOT_W=8 and the HOLD_CYCLES default.
REQ-032 One sub-module is natural: a combinational code-to-one-hot function/module onehot_3x8, instantiated for both the in_code path and the pending-code path, or for one muxed path.
REQ-033 Counter width is 8 bits.

Verification
REQ-034 Single code: HOLD_CYCLES=4; in_code=5 accepted at cycle 0 -> OUT=8'b0010_0000 for cycles 1-4, OUT=0 at cycle 5, decode_count=1.
REQ-035 Back-to-back: codes 0,7,3 presented continuously -> OUT=01,80,08 each for 4 contiguous cycles; in_ready=0 while the pending slot is full; decode_count=3.
REQ-036 Bypass at boundary: code 2 is accepted exactly on the counter=0 cycle with pending empty -> OUT goes 04 with no zero gap.
REQ-037 Abort: abort during HOLD of code 6 with code 1 pending -> OUT=0 next cycle, code 1 is never output, decode_count unchanged.
REQ-038 Reset mid-operation: rst during HOLD -> OUT=0, decode_count=0, in_ready=0 while reset; a code accepted after release decodes normally.
REQ-039 Wrap and one-hot check: 257 codes with HOLD_CYCLES=1 -> decode_count=1; every cycle OUT is zero or has exactly one bit set, and the set bit matches the expected code sequence.
